systolic_feeder: RTL and testbench
==================================

Name: systolic_feeder

Overview:
- Upstream stage of the systolic multiply array. Captures an NxN operand pair (A, B) on a start handshake and clears the array's PE accumulators.
- Streams A rows into the west edge and B columns into the north edge with diagonal skew and zero padding.
- Pulses done when every PE(i,j) has accumulated the full dot product of A row i and B column j.

Parameters:
- N, 4, array dimension (rows = columns = lanes)
- DW, 8, operand element width (matches PE input width)

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-low reset
- start  input  1  request; accepted only in IDLE
- a_flat  input  N*N*DW  matrix A; A[i][k] at bits [(i*N+k)*DW +: DW]
- b_flat  input  N*N*DW  matrix B; B[k][j] at bits [(k*N+j)*DW +: DW]
- busy  output  1  high from the cycle after acceptance through the DONE cycle
- done  output  1  one-cycle pulse; array results are valid from this cycle on
- pe_rst  output  1  active-low synchronous clear driven to every PE's rst
- west_out  output  N*DW  lane i at [i*DW +: DW], drives inp_west of PE(i,0)
- north_out  output  N*DW  lane j at [j*DW +: DW], drives inp_north of PE(0,j)

Behaviour:
- Reset: one clock, clk. Reset is asynchronous and active-low on rst. While rst=0: state=IDLE, busy=0, done=0, pe_rst=0 (array held clear), west_out=0, north_out=0, t=0, operand registers=0.
- All outputs are registered.
- States: IDLE, CLEAR, FEED, DONE.
- IDLE:
  - pe_rst=1, lanes=0.
  - start=1 at an edge: capture a_flat/b_flat into internal registers and go to CLEAR.
- CLEAR (1 cycle): pe_rst=0, lanes=0, busy=1. PEs clear at the edge that ends this cycle. Next state FEED with t=0.
- FEED (3N-2 cycles, t=0..3N-3): pe_rst=1, busy=1.
  - west lane i = A[i][t-i] if 0 <= t-i < N, else 0.
  - north lane j = B[t-j][j] if 0 <= t-j < N, else 0.
  - PE(i,j) therefore sees matching k = T-i-j after the array's internal forwarding delays.
  - t increments each cycle. After t=3N-3, go to DONE.
- DONE (1 cycle): done=1, busy=1, lanes=0, pe_rst=1. Next state IDLE.
- Latency: acceptance edge to done high = 3N-1 cycles (11 for N=4).
- After done, results stay held in the array until the next acceptance, because pe_rst stays 1 and lanes stay zero.
- start while not IDLE: ignored, with no queueing. Operand inputs may change freely after acceptance.
- start=1 continuously: a new run is accepted in the IDLE cycle following DONE, giving back-to-back runs with a one-cycle gap.
- t counter width: clog2(3N-2) bits. No wrap occurs within a run; t is reset to 0 on entry to FEED.
- Reset mid-run: aborts immediately. Outputs take their reset values and pe_rst=0 clears partial sums. No done is produced for the aborted run.
- Zero padding is exact: lanes outside the valid window drive 0, so the PE accumulators are unaffected.

Decomposition:
- Shared package systolic_pkg:
  - state enum (IDLE, CLEAR, FEED, DONE)
  - default N and DW
  - function feed_len(N) = 3N-2
  - lane index/slice helper constants
- One natural sub-module: feeder_lane (combinational select). Instantiated 2N times. Inputs: lane index, t, and the captured row/column. Output: the element or 0.
- The top level owns the FSM, the t counter and the output registers.

Test Plan:
- N=4, A=identity, B[k][j]=4k+j+1, start pulse at edge 0 -> busy 1..11, done only at cycle 11. Array results R[i][j]=B[i][j] (e.g. R[2][3]=12).
- Trace check, A[i][k]=10i+k -> west lane 0 reads 0,1,2,3,0.. over t=0..4. Lane 3 reads 0,0,0,30,31,32,33,0 over t=0..7. North lane 2 is zero for t<2.
- A all 2, B all 3 -> every R[i][j]=24. pe_rst low exactly one cycle (the CLEAR cycle).
- start held high across a run -> start ignored while busy. Second run accepted the cycle after done. New operands captured and the previous result cleared by the second CLEAR.
- rst asserted at FEED t=4 -> outputs zero and pe_rst=0 asynchronously, state IDLE after release. A following run gives correct results.
- a_flat changed every cycle during FEED -> outputs reflect only the values captured at acceptance.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array feeder.
// Holds the feeder state encoding, default array geometry, and small helpers
// that size the feed counter and locate elements inside flattened buses.
package systolic_pkg;

  localparam int N_DEFAULT  = 4;
  localparam int DW_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    FEED  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Number of FEED cycles: the last PE (N-1,N-1) meets k=N-1 at t=3N-3.
  function automatic int feed_len(input int n);
    return 3 * n - 2;
  endfunction

  // Width of the feed counter; at least one bit so N=1 still elaborates.
  function automatic int t_width(input int n);
    return (feed_len(n) > 1) ? $clog2(feed_len(n)) : 1;
  endfunction

  // LSB of lane/element `lane` in a bus of dw-wide lanes.
  function automatic int lane_lsb(input int lane, input int dw);
    return lane * dw;
  endfunction

  // LSB of matrix element [row][col] in a row-major flattened NxN matrix.
  function automatic int elem_lsb(input int row, input int col, input int n, input int dw);
    return (row * n + col) * dw;
  endfunction

endpackage

// File: rtl/systolic_feeder_if.sv
// Bus between the feeder and whoever launches a multiply.
//   start    : request, honoured only while the feeder is idle
//   a_flat   : matrix A, A[i][k] at [(i*N+k)*DW +: DW]
//   b_flat   : matrix B, B[k][j] at [(k*N+j)*DW +: DW]
//   busy     : feeder owns the array (CLEAR through DONE)
//   done     : one-cycle pulse, array results valid from here on
//   pe_rst   : active-low synchronous clear for every PE
//   west_out : lane i feeds inp_west of PE(i,0)
//   north_out: lane j feeds inp_north of PE(0,j)
// master = requester side, slave = the feeder itself.
interface systolic_feeder_if
  import systolic_pkg::*;
#(
  parameter int N  = N_DEFAULT,
  parameter int DW = DW_DEFAULT
);

  logic              start;
  logic [N*N*DW-1:0] a_flat;
  logic [N*N*DW-1:0] b_flat;
  logic              busy;
  logic              done;
  logic              pe_rst;
  logic [N*DW-1:0]   west_out;
  logic [N*DW-1:0]   north_out;

  modport master (
    output start, a_flat, b_flat,
    input  busy, done, pe_rst, west_out, north_out
  );

  modport slave (
    input  start, a_flat, b_flat,
    output busy, done, pe_rst, west_out, north_out
  );

endinterface

// File: rtl/systolic_feeder_lane.sv
// One skewed edge lane of the feeder (purely combinational).
//   idx  : lane number (row for west lanes, column for north lanes)
//   t    : feed step being presented
//   vec  : captured row of A or column of B, element k at [k*DW +: DW]
//   elem : vec[t-idx] when 0 <= t-idx < N, otherwise 0
module feeder_lane
  import systolic_pkg::*;
#(
  parameter int N  = N_DEFAULT,
  parameter int DW = DW_DEFAULT,
  parameter int TW = t_width(N_DEFAULT)
) (
  input  logic [TW-1:0]   idx,
  input  logic [TW-1:0]   t,
  input  logic [N*DW-1:0] vec,
  output logic [DW-1:0]   elem
);

  // Matching t against idx+k avoids a subtraction with a sign check;
  // idx+k stays below 2N-1 <= 3N-2, so it never wraps in TW bits.
  always_comb begin
    elem = '0;
    for (int k = 0; k < N; k++) begin
      if (t == idx + TW'(k)) begin
        elem = vec[lane_lsb(k, DW) +: DW];
      end
    end
  end

endmodule

// File: rtl/systolic_feeder.sv
// Upstream stage of the systolic multiply array.
// Captures A and B on an accepted start, clears the PE accumulators for one
// cycle, then streams A rows west and B columns north with diagonal skew and
// zero padding, finishing with a one-cycle done pulse.
//   clk : system clock
//   rst : asynchronous active-low reset
//   bus : systolic_feeder_if slave (start/operands in, status/lanes out)
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int N  = N_DEFAULT,
  parameter int DW = DW_DEFAULT
) (
  input logic              clk,
  input logic              rst,
  systolic_feeder_if.slave bus
);

  localparam int            FEED_LEN = feed_len(N);
  localparam int            TW       = t_width(N);
  localparam logic [TW-1:0] T_LAST   = TW'(FEED_LEN - 1);

  state_t            state, state_next;
  logic [TW-1:0]     t, t_next;
  logic [N*N*DW-1:0] a_reg, b_reg;
  logic [N*DW-1:0]   b_col [N];
  logic              busy_q, done_q, pe_rst_q;
  logic              busy_next, done_next, pe_rst_next;
  logic              lanes_en, capture;
  logic [N*DW-1:0]   west_q, north_q;
  wire  [N*DW-1:0]   west_sel, north_sel;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      t     <= '0;
    end else begin
      state <= state_next;
      t     <= t_next;
    end
  end

  // Next-state logic also computes the values the output registers take at
  // the same edge, so every output reflects the state it is presented in.
  always_comb begin
    state_next  = state;
    t_next      = t;
    busy_next   = 1'b0;
    done_next   = 1'b0;
    pe_rst_next = 1'b1;
    lanes_en    = 1'b0;
    capture     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_next  = CLEAR;
          busy_next   = 1'b1;
          pe_rst_next = 1'b0;
          capture     = 1'b1;
        end
      end
      CLEAR: begin
        state_next = FEED;
        t_next     = '0;
        busy_next  = 1'b1;
        lanes_en   = 1'b1;
      end
      FEED: begin
        busy_next = 1'b1;
        if (t == T_LAST) begin
          state_next = DONE;
          done_next  = 1'b1;
        end else begin
          t_next   = t + 1'b1;
          lanes_en = 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // B is stored row-major; each north lane needs a column, so regroup it.
  always_comb begin
    for (int j = 0; j < N; j++) begin
      b_col[j] = '0;
      for (int k = 0; k < N; k++) begin
        b_col[j][lane_lsb(k, DW) +: DW] = b_reg[elem_lsb(k, j, N, DW) +: DW];
      end
    end
  end

  // Lanes select on t_next so the registered lane value lines up with the
  // feed step the FSM is entering.
  for (genvar i = 0; i < N; i++) begin : g_lane
    feeder_lane #(.N(N), .DW(DW), .TW(TW)) u_west (
      .idx  (TW'(i)),
      .t    (t_next),
      .vec  (a_reg[i*N*DW +: N*DW]),
      .elem (west_sel[i*DW +: DW])
    );
    feeder_lane #(.N(N), .DW(DW), .TW(TW)) u_north (
      .idx  (TW'(i)),
      .t    (t_next),
      .vec  (b_col[i]),
      .elem (north_sel[i*DW +: DW])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_reg    <= '0;
      b_reg    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pe_rst_q <= 1'b0;
      west_q   <= '0;
      north_q  <= '0;
    end else begin
      if (capture) begin
        a_reg <= bus.a_flat;
        b_reg <= bus.b_flat;
      end
      busy_q   <= busy_next;
      done_q   <= done_next;
      pe_rst_q <= pe_rst_next;
      west_q   <= lanes_en ? west_sel : '0;
      north_q  <= lanes_en ? north_sel : '0;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pe_rst    = pe_rst_q;
  assign bus.west_out  = west_q;
  assign bus.north_out = north_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// Self-checking bench for systolic_feeder.
// Lanes are compared against A/B indexed by the skew rule; the PE array is
// modelled abstractly by pairing the recorded west/north lane streams with
// their forwarding delays and comparing each sum with the plain matrix product.
module tb_systolic_feeder;
  import systolic_pkg::*;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int NN = N * N * DW;
  localparam int LW = N * DW;
  localparam int FL = feed_len(N);

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  systolic_feeder_if #(.N(N), .DW(DW)) bus ();

  systolic_feeder #(.N(N), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] ctrl();
    return 64'({bus.busy, bus.done, bus.pe_rst});
  endfunction

  function automatic int elem_of(input logic [NN-1:0] m, input int r, input int c);
    logic [NN-1:0] s;
    s = m >> ((r * N + c) * DW);
    return int'(s[DW-1:0]);
  endfunction

  function automatic int lane_of(input logic [LW-1:0] v, input int l);
    logic [LW-1:0] s;
    s = v >> (l * DW);
    return int'(s[DW-1:0]);
  endfunction

  // kind: 0 identity, 1 4r+c+1, 2 10r+c, 3 all 2, 4 all 3, else random
  function automatic logic [NN-1:0] mk_mat(input int kind);
    logic [NN-1:0] m;
    int v;
    m = '0;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        case (kind)
          0:       v = (r == c) ? 1 : 0;
          1:       v = 4 * r + c + 1;
          2:       v = 10 * r + c;
          3:       v = 2;
          4:       v = 3;
          default: v = int'($urandom_range(0, 255));
        endcase
        m = m | (NN'(v & ((1 << DW) - 1)) << ((r * N + c) * DW));
      end
    end
    return m;
  endfunction

  // West lane l at step t carries A[l][t-l]; north lane l carries B[t-l][l].
  function automatic logic [LW-1:0] lane_ref(input logic [NN-1:0] m, input int t, input bit is_west);
    logic [LW-1:0] r;
    int k, v;
    r = '0;
    for (int l = 0; l < N; l++) begin
      k = t - l;
      if (k >= 0 && k < N) begin
        v = is_west ? elem_of(m, l, k) : elem_of(m, k, l);
        r = r | (LW'(v) << (l * DW));
      end
    end
    return r;
  endfunction

  task automatic run_check(input string tag, input logic [NN-1:0] a, input logic [NN-1:0] b,
                           input bit hold, input bit scramble);
    logic [LW-1:0] wtr [FL];
    logic [LW-1:0] ntr [FL];
    int acc, expv, t2;
    bus.a_flat = a;
    bus.b_flat = b;
    bus.start  = 1'b1;
    tick();
    if (!hold) bus.start = 1'b0;
    check($sformatf("%s_clear_ctrl", tag), ctrl(), 64'(3'b100));
    check($sformatf("%s_clear_west", tag), 64'(bus.west_out), 64'(0));
    check($sformatf("%s_clear_north", tag), 64'(bus.north_out), 64'(0));
    for (int t = 0; t < FL; t++) begin
      tick();
      if (scramble) begin
        bus.a_flat = mk_mat(9);
        bus.b_flat = mk_mat(9);
      end
      check($sformatf("%s_feed%0d_ctrl", tag, t), ctrl(), 64'(3'b101));
      check($sformatf("%s_feed%0d_west", tag, t), 64'(bus.west_out), 64'(lane_ref(a, t, 1'b1)));
      check($sformatf("%s_feed%0d_north", tag, t), 64'(bus.north_out), 64'(lane_ref(b, t, 1'b0)));
      wtr[t] = bus.west_out;
      ntr[t] = bus.north_out;
    end
    tick();
    check($sformatf("%s_done_ctrl", tag), ctrl(), 64'(3'b111));
    check($sformatf("%s_done_lanes", tag), 64'({bus.west_out, bus.north_out}), 64'(0));
    // PE(i,j) meets west step t together with north step t+j-i.
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        acc  = 0;
        expv = 0;
        for (int t = 0; t < FL; t++) begin
          t2 = t + j - i;
          if (t2 >= 0 && t2 < FL) acc += lane_of(wtr[t], i) * lane_of(ntr[t2], j);
        end
        for (int k = 0; k < N; k++) expv += elem_of(a, i, k) * elem_of(b, k, j);
        check($sformatf("%s_R%0d%0d", tag, i, j), 64'(acc), 64'(expv));
      end
    end
    tick();
    check($sformatf("%s_idle_ctrl", tag), ctrl(), 64'(3'b001));
    check($sformatf("%s_idle_lanes", tag), 64'({bus.west_out, bus.north_out}), 64'(0));
  endtask

  initial begin
    rst        = 1'b0;
    bus.start  = 1'b0;
    bus.a_flat = '0;
    bus.b_flat = '0;
    #3;
    check("reset_ctrl", ctrl(), 64'(3'b000));
    check("reset_lanes", 64'({bus.west_out, bus.north_out}), 64'(0));
    #9 rst = 1'b1;
    tick();
    check("idle_ctrl", ctrl(), 64'(3'b001));

    $display("[TB] identity times counting matrix");
    run_check("ident", mk_mat(0), mk_mat(1), 1'b0, 1'b0);
    $display("[TB] skew trace with A=10i+k");
    run_check("trace", mk_mat(2), mk_mat(9), 1'b0, 1'b0);
    $display("[TB] constant operands");
    run_check("const", mk_mat(3), mk_mat(4), 1'b0, 1'b0);
    $display("[TB] start held high for back-to-back runs");
    run_check("hold1", mk_mat(9), mk_mat(9), 1'b1, 1'b0);
    run_check("hold2", mk_mat(9), mk_mat(9), 1'b0, 1'b0);
    $display("[TB] operands scrambled after acceptance");
    run_check("scramble", mk_mat(9), mk_mat(9), 1'b0, 1'b1);

    $display("[TB] reset during FEED");
    bus.a_flat = mk_mat(9);
    bus.b_flat = mk_mat(9);
    bus.start  = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (5) tick();
    check("abort_pre_ctrl", ctrl(), 64'(3'b101));
    #2 rst = 1'b0;
    #1;
    check("abort_ctrl", ctrl(), 64'(3'b000));
    check("abort_lanes", 64'({bus.west_out, bus.north_out}), 64'(0));
    tick();
    #2 rst = 1'b1;
    tick();
    check("abort_idle_ctrl", ctrl(), 64'(3'b001));
    for (int c = 0; c < 3 * N; c++) begin
      tick();
      check($sformatf("abort_no_done%0d", c), ctrl(), 64'(3'b001));
    end
    run_check("after_reset", mk_mat(9), mk_mat(9), 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
